bin_search_ctrl: RTL and testbench
==================================

Name: bin_search_ctrl

Overview:
- Per-bin sequencer for the array of SAT base cells.
- Drives the load → propagate → decide → analyze → backtrack → update flow for the current bin, and owns the decision-level counter.
- Sits between the bin scheduler (start/done/result) and the cell array (apply_* strobes, decide one-hot, level/backtrack buses).
- Consumes OR-reduced conflict, per-var imply and per-var free vectors, plus the externally computed max backtrack level.

Parameters:
- NUM_VARS, 8, variables per bin (width of the one-hot and status vectors).
- NUM_CLAUSES_A_BIN, 24, clause rows per bin; sets the load/update beat count.
- WIDTH_LVL, 16, decision-level width.
- STABLE_CYCLES, 2, consecutive unchanged imply_vec_i cycles that count as propagation settled.
- ANALYZE_CYCLES, 2, cycles apply_analyze_o is held.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start_i  in  1  begin processing a bin; sampled only in IDLE
- base_lvl_i  in  WIDTH_LVL  decision level on bin entry
- imply_vec_i  in  NUM_VARS  per-var find_imply from cells
- free_vec_i  in  NUM_VARS  1 = var unassigned
- conflict_i  in  1  OR of cell find_conflict
- max_lvl_i  in  WIDTH_LVL  max of cell var_level_o (backtrack target)
- apply_load_o  out  1  load strobe to cells
- apply_update_o  out  1  update strobe to cells
- clause_idx_o  out  5  clause row index during LOAD/UPDATE
- vars_decided_o  out  NUM_VARS  one-hot decide pulse
- decide_level_o  out  WIDTH_LVL  current decision level
- apply_analyze_o  out  1  analyze strobe
- apply_backtrack_o  out  1  backtrack strobe
- bkt_lvl_o  out  WIDTH_LVL  backtrack level
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse
- result_o  out  2  01 bin SAT, 10 global UNSAT, 11 backtrack out of bin; held until next done_o

Behaviour:
- Reset (rst==0 at clk edge):
  - state = IDLE, all counters = 0.
  - Every output = 0: all strobes, vars_decided_o, decide_level_o, bkt_lvl_o, result_o, done_o, busy_o.
  - Reset mid-operation aborts with no done_o.
- Outputs are registered; each value is valid in the state named.
- IDLE:
  - start_i=1 → LOAD; clause_idx_o=0; decide_level_o=base_lvl_i.
  - start_i while busy is ignored.
- LOAD:
  - apply_load_o=1 for exactly NUM_CLAUSES_A_BIN cycles; clause_idx_o counts 0..N-1.
  - After the last beat → IMPLY with the stable counter cleared.
- IMPLY:
  - Each cycle, compare imply_vec_i with its registered previous value.
  - Equal → stable_cnt+1; different → clear stable_cnt.
  - conflict_i=1 has priority over everything: → ANALYZE.
  - stable_cnt==STABLE_CYCLES-1 and no conflict:
    - free_vec_i==0 → UPDATE.
    - otherwise → DECIDE; in the same edge load vars_decided_o = lowest set bit of free_vec_i and decide_level_o += 1.
- DECIDE:
  - Exactly one cycle; vars_decided_o and the new decide_level_o are valid together.
  - Then vars_decided_o = 0 → IMPLY, stable counter cleared.
  - decide_level_o saturates at all-ones and never wraps.
- ANALYZE:
  - apply_analyze_o=1 for ANALYZE_CYCLES cycles; max_lvl_i is sampled on the last cycle.
  - If decide_level_o==0 → result 10, go to DONE.
  - Else if max_lvl_i < base_lvl_i → bkt_lvl_o=max_lvl_i, result 11, go to DONE.
  - Else → bkt_lvl_o=max_lvl_i, go to BACKTRACK.
- BACKTRACK:
  - apply_backtrack_o=1 for one cycle; decide_level_o=bkt_lvl_o at exit.
  - Then → IMPLY with the stable counter cleared.
- UPDATE:
  - apply_update_o=1 for NUM_CLAUSES_A_BIN cycles; clause_idx_o counts 0..N-1.
  - Then result 01 → DONE.
- DONE:
  - done_o=1 for one cycle, then → IDLE.
  - result_o and bkt_lvl_o persist until the next DONE.
- Mutual exclusion: at most one of apply_load_o, apply_update_o, apply_analyze_o, apply_backtrack_o is ever high, and none of them is high in the same cycle as vars_decided_o.

Optional Feature:
- Macro: BIN_SEARCH_CTRL_STATS_EN.
- Defined:
  - Adds outputs decision_cnt_o[15:0] and conflict_cnt_o[15:0].
  - decision_cnt_o increments on each DECIDE entry; conflict_cnt_o increments on each ANALYZE entry.
  - Both saturate at 16'hFFFF and clear on reset and on start_i accepted in IDLE.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load/update with no frees: start_i, base_lvl_i=3, free_vec_i=0, imply stable → 24 load beats with idx 0..23, IMPLY for 2 cycles, 24 update beats, done_o with result_o=01, decide_level_o=3.
- Decide priority: free_vec_i=8'b0010_1000 after stable → vars_decided_o=8'b0000_1000 for exactly one cycle, decide_level_o 3→4.
- Conflict inside bin: at level 5 with base 3, conflict_i=1, max_lvl_i=4 → 2 analyze cycles, apply_backtrack_o for 1 cycle with bkt_lvl_o=4, decide_level_o=4, returns to IMPLY.
- Backtrack out: base 3, max_lvl_i=1 → done_o, result_o=11, bkt_lvl_o=1, no apply_backtrack_o.
- Global UNSAT and priority: base 0, conflict_i=1 in the same cycle imply becomes stable → ANALYZE is taken, then result_o=10; separately, rst=0 during UPDATE → all outputs 0 next cycle and no done_o.
- With BIN_SEARCH_CTRL_STATS_EN: 3 decisions and 1 conflict → decision_cnt_o=3, conflict_cnt_o=1; both clear on the next accepted start_i.

Source files
------------

// File: rtl/bin_search_ctrl.sv
// Per-bin SAT search sequencer: load -> propagate -> decide -> analyze -> backtrack -> update.
// Define BIN_SEARCH_CTRL_STATS_EN to add saturating decision/conflict counters.
module bin_search_ctrl #(
   parameter int NUM_VARS          = 8,
   parameter int NUM_CLAUSES_A_BIN = 24,
   parameter int WIDTH_LVL         = 16,
   parameter int STABLE_CYCLES     = 2,
   parameter int ANALYZE_CYCLES    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [WIDTH_LVL-1:0] base_lvl_i,
   input  logic [NUM_VARS-1:0]  imply_vec_i,
   input  logic [NUM_VARS-1:0]  free_vec_i,
   input  logic                 conflict_i,
   input  logic [WIDTH_LVL-1:0] max_lvl_i,
   output logic                 apply_load_o,
   output logic                 apply_update_o,
   output logic [4:0]           clause_idx_o,
   output logic [NUM_VARS-1:0]  vars_decided_o,
   output logic [WIDTH_LVL-1:0] decide_level_o,
   output logic                 apply_analyze_o,
   output logic                 apply_backtrack_o,
   output logic [WIDTH_LVL-1:0] bkt_lvl_o,
   output logic                 busy_o,
   output logic                 done_o,
`ifdef BIN_SEARCH_CTRL_STATS_EN
   output logic [15:0]          decision_cnt_o,
   output logic [15:0]          conflict_cnt_o,
`endif
   output logic [1:0]           result_o
);

   localparam int SCW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int ACW = (ANALYZE_CYCLES > 1) ? $clog2(ANALYZE_CYCLES) : 1;
   localparam logic [4:0]     IDX_LAST     = 5'(NUM_CLAUSES_A_BIN - 1);
   localparam logic [SCW-1:0] STABLE_LAST  = SCW'(STABLE_CYCLES - 1);
   localparam logic [ACW-1:0] ANALYZE_LAST = ACW'(ANALYZE_CYCLES - 1);

   localparam logic [1:0] RES_SAT     = 2'b01;
   localparam logic [1:0] RES_UNSAT   = 2'b10;
   localparam logic [1:0] RES_BKT_OUT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_IMPLY,
      S_DECIDE,
      S_ANALYZE,
      S_BACKTRACK,
      S_UPDATE,
      S_DONE
   } state_e;

   state_e               state_q;
   logic [4:0]           clause_idx_q;
   logic [SCW-1:0]       stable_cnt_q;
   logic [ACW-1:0]       analyze_cnt_q;
   logic [NUM_VARS-1:0]  imply_prev_q;
   logic [WIDTH_LVL-1:0] base_q;
   logic [WIDTH_LVL-1:0] decide_level_q;
   logic [WIDTH_LVL-1:0] bkt_lvl_q;
   logic [NUM_VARS-1:0]  vars_decided_q;
   logic [1:0]           result_q;
   logic                 load_q;
   logic                 update_q;
   logic                 analyze_q;
   logic                 backtrack_q;
   logic                 busy_q;
   logic                 done_q;

   logic                 imply_equal;
   logic                 settled;
   logic [SCW-1:0]       stable_cnt_d;
   logic [WIDTH_LVL-1:0] decide_level_d;
   logic [NUM_VARS-1:0]  decide_onehot_d;

   assign imply_equal     = (imply_vec_i == imply_prev_q);
   assign settled         = imply_equal && (stable_cnt_q == STABLE_LAST);
   assign stable_cnt_d    = imply_equal ? stable_cnt_q + SCW'(1) : '0;
   // Level saturates at all-ones so a deep search can never wrap to level 0.
   assign decide_level_d  = (&decide_level_q) ? decide_level_q : decide_level_q + WIDTH_LVL'(1);
   assign decide_onehot_d = free_vec_i & (~free_vec_i + NUM_VARS'(1));

`ifdef BIN_SEARCH_CTRL_STATS_EN
   logic [15:0] decision_cnt_q;
   logic [15:0] conflict_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         decision_cnt_q <= '0;
         conflict_cnt_q <= '0;
      end else if (state_q == S_IDLE && start_i) begin
         decision_cnt_q <= '0;
         conflict_cnt_q <= '0;
      end else if (state_q == S_IMPLY) begin
         if (conflict_i) begin
            conflict_cnt_q <= conflict_cnt_q + 16'(conflict_cnt_q != 16'hFFFF);
         end else if (settled && free_vec_i != '0) begin
            decision_cnt_q <= decision_cnt_q + 16'(decision_cnt_q != 16'hFFFF);
         end
      end
   end

   assign decision_cnt_o = decision_cnt_q;
   assign conflict_cnt_o = conflict_cnt_q;
`endif

   // NOTE: sequential state uses non-blocking (<=) only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous: it is a plain branch inside the clocked block,
      // not in the sensitivity list.
      if (!rst) begin
         state_q        <= S_IDLE;
         clause_idx_q   <= '0;
         stable_cnt_q   <= '0;
         analyze_cnt_q  <= '0;
         imply_prev_q   <= '0;
         base_q         <= '0;
         decide_level_q <= '0;
         bkt_lvl_q      <= '0;
         vars_decided_q <= '0;
         result_q       <= '0;
         load_q         <= 1'b0;
         update_q       <= 1'b0;
         analyze_q      <= 1'b0;
         backtrack_q    <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         imply_prev_q <= imply_vec_i;
         done_q       <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q        <= S_LOAD;
                  busy_q         <= 1'b1;
                  load_q         <= 1'b1;
                  clause_idx_q   <= '0;
                  base_q         <= base_lvl_i;
                  decide_level_q <= base_lvl_i;
               end
            end

            S_LOAD: begin
               if (clause_idx_q == IDX_LAST) begin
                  state_q      <= S_IMPLY;
                  load_q       <= 1'b0;
                  clause_idx_q <= '0;
                  stable_cnt_q <= '0;
               end else begin
                  clause_idx_q <= clause_idx_q + 5'd1;
               end
            end

            S_IMPLY: begin
               if (conflict_i) begin
                  state_q       <= S_ANALYZE;
                  analyze_q     <= 1'b1;
                  analyze_cnt_q <= '0;
               end else if (settled) begin
                  stable_cnt_q <= '0;
                  if (free_vec_i == '0) begin
                     state_q      <= S_UPDATE;
                     update_q     <= 1'b1;
                     clause_idx_q <= '0;
                  end else begin
                     state_q        <= S_DECIDE;
                     vars_decided_q <= decide_onehot_d;
                     decide_level_q <= decide_level_d;
                  end
               end else begin
                  stable_cnt_q <= stable_cnt_d;
               end
            end

            S_DECIDE: begin
               state_q        <= S_IMPLY;
               vars_decided_q <= '0;
               stable_cnt_q   <= '0;
            end

            S_ANALYZE: begin
               if (analyze_cnt_q == ANALYZE_LAST) begin
                  analyze_q     <= 1'b0;
                  analyze_cnt_q <= '0;
                  if (decide_level_q == '0) begin
                     state_q  <= S_DONE;
                     result_q <= RES_UNSAT;
                     done_q   <= 1'b1;
                  end else begin
                     bkt_lvl_q <= max_lvl_i;
                     // A target below the entry level belongs to an earlier bin.
                     if (max_lvl_i < base_q) begin
                        state_q  <= S_DONE;
                        result_q <= RES_BKT_OUT;
                        done_q   <= 1'b1;
                     end else begin
                        state_q     <= S_BACKTRACK;
                        backtrack_q <= 1'b1;
                     end
                  end
               end else begin
                  analyze_cnt_q <= analyze_cnt_q + ACW'(1);
               end
            end

            S_BACKTRACK: begin
               state_q        <= S_IMPLY;
               backtrack_q    <= 1'b0;
               decide_level_q <= bkt_lvl_q;
               stable_cnt_q   <= '0;
            end

            S_UPDATE: begin
               if (clause_idx_q == IDX_LAST) begin
                  state_q      <= S_DONE;
                  update_q     <= 1'b0;
                  clause_idx_q <= '0;
                  result_q     <= RES_SAT;
                  done_q       <= 1'b1;
               end else begin
                  clause_idx_q <= clause_idx_q + 5'd1;
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign apply_load_o      = load_q;
   assign apply_update_o    = update_q;
   assign clause_idx_o      = clause_idx_q;
   assign vars_decided_o    = vars_decided_q;
   assign decide_level_o    = decide_level_q;
   assign apply_analyze_o   = analyze_q;
   assign apply_backtrack_o = backtrack_q;
   assign bkt_lvl_o         = bkt_lvl_q;
   assign busy_o            = busy_q;
   assign done_o            = done_q;
   assign result_o          = result_q;

   strobe_mutex_a: assert property (@(posedge clk) disable iff (!rst)
      $onehot0({load_q, update_q, analyze_q, backtrack_q, |vars_decided_q}));

endmodule

// File: tb/tb_bin_search_ctrl.sv
// Directed self-checking bench for bin_search_ctrl (default parameters).
// Stats checks are compiled in when BIN_SEARCH_CTRL_STATS_EN is defined.
module tb_bin_search_ctrl;

   localparam int NC = 24;

   localparam int W_LOAD_END  = 0;
   localparam int W_DECIDE    = 1;
   localparam int W_ANALYZE   = 2;
   localparam int W_DONE      = 3;
   localparam int W_UPDATE    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] base_lvl_i = '0;
   logic [7:0]  imply_vec_i = 8'h5A;
   logic [7:0]  free_vec_i = '0;
   logic        conflict_i = 1'b0;
   logic [15:0] max_lvl_i = '0;
   logic        apply_load_o;
   logic        apply_update_o;
   logic [4:0]  clause_idx_o;
   logic [7:0]  vars_decided_o;
   logic [15:0] decide_level_o;
   logic        apply_analyze_o;
   logic        apply_backtrack_o;
   logic [15:0] bkt_lvl_o;
   logic        busy_o;
   logic        done_o;
   logic [1:0]  result_o;
`ifdef BIN_SEARCH_CTRL_STATS_EN
   logic [15:0] decision_cnt_o;
   logic [15:0] conflict_cnt_o;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   bin_search_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .start_i           (start_i),
      .base_lvl_i        (base_lvl_i),
      .imply_vec_i       (imply_vec_i),
      .free_vec_i        (free_vec_i),
      .conflict_i        (conflict_i),
      .max_lvl_i         (max_lvl_i),
      .apply_load_o      (apply_load_o),
      .apply_update_o    (apply_update_o),
      .clause_idx_o      (clause_idx_o),
      .vars_decided_o    (vars_decided_o),
      .decide_level_o    (decide_level_o),
      .apply_analyze_o   (apply_analyze_o),
      .apply_backtrack_o (apply_backtrack_o),
      .bkt_lvl_o         (bkt_lvl_o),
      .busy_o            (busy_o),
      .done_o            (done_o),
`ifdef BIN_SEARCH_CTRL_STATS_EN
      .decision_cnt_o    (decision_cnt_o),
      .conflict_cnt_o    (conflict_cnt_o),
`endif
      .result_o          (result_o)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Start a bin; returns on the negedge where the first load beat is visible.
   task automatic start_bin(input logic [15:0] base);
      start_i    = 1'b1;
      base_lvl_i = base;
      step(1);
      start_i    = 1'b0;
   endtask

   task automatic wait_for(input int which, input int budget, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         case (which)
            W_LOAD_END: seen = (apply_load_o === 1'b0);
            W_DECIDE:   seen = (vars_decided_o !== 8'h00) && !$isunknown(vars_decided_o);
            W_ANALYZE:  seen = (apply_analyze_o === 1'b1);
            W_DONE:     seen = (done_o === 1'b1);
            W_UPDATE:   seen = (apply_update_o === 1'b1);
            default:    seen = 1'b0;
         endcase
         if (seen) break;
         step(1);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      step(2);
      total_cnt++;
      if ({apply_load_o, apply_update_o, apply_analyze_o, apply_backtrack_o, busy_o, done_o} !== 6'b0)
         $display("FAIL reset_strobes: got %b, expected 000000",
                  {apply_load_o, apply_update_o, apply_analyze_o, apply_backtrack_o, busy_o, done_o});
      else pass_cnt++;
      total_cnt++;
      if (vars_decided_o !== 8'h00 || clause_idx_o !== 5'd0)
         $display("FAIL reset_vars_idx: vars=%h idx=%0d, expected 00 and 0", vars_decided_o, clause_idx_o);
      else pass_cnt++;
      total_cnt++;
      if (decide_level_o !== 16'd0 || bkt_lvl_o !== 16'd0 || result_o !== 2'b00)
         $display("FAIL reset_levels: lvl=%0d bkt=%0d res=%b, expected 0 0 00",
                  decide_level_o, bkt_lvl_o, result_o);
      else pass_cnt++;
`ifdef BIN_SEARCH_CTRL_STATS_EN
      total_cnt++;
      if (decision_cnt_o !== 16'd0 || conflict_cnt_o !== 16'd0)
         $display("FAIL reset_stats: dec=%0d conf=%0d, expected 0 0", decision_cnt_o, conflict_cnt_o);
      else pass_cnt++;
`endif
      rst = 1'b1;
      step(2);
      total_cnt++;
      if (busy_o !== 1'b0)
         $display("FAIL idle_no_start: busy=%b, expected 0", busy_o);
      else pass_cnt++;
   endtask

   task automatic test_load_update;
      int n;
      free_vec_i = 8'h00;
      conflict_i = 1'b0;
      start_bin(16'd3);
      for (int i = 0; i < NC; i++) begin
         start_i    = (i == 5);
         base_lvl_i = (i == 5) ? 16'd7 : 16'd3;
         total_cnt++;
         if (apply_load_o !== 1'b1 || clause_idx_o !== 5'(i) || decide_level_o !== 16'd3 || busy_o !== 1'b1)
            $display("FAIL load_beat%0d: load=%b idx=%0d lvl=%0d busy=%b, expected 1 %0d 3 1",
                     i, apply_load_o, clause_idx_o, decide_level_o, busy_o, i);
         else pass_cnt++;
         step(1);
      end
      start_i = 1'b0;
      n = 0;
      while (apply_update_o !== 1'b1 && n < 10) begin
         n++;
         step(1);
      end
      total_cnt++;
      if (n !== 2)
         $display("FAIL imply_cycles: got %0d, expected 2", n);
      else pass_cnt++;
      for (int i = 0; i < NC; i++) begin
         total_cnt++;
         if (apply_update_o !== 1'b1 || clause_idx_o !== 5'(i) || apply_load_o !== 1'b0)
            $display("FAIL update_beat%0d: upd=%b idx=%0d load=%b, expected 1 %0d 0",
                     i, apply_update_o, clause_idx_o, apply_load_o, i);
         else pass_cnt++;
         step(1);
      end
      total_cnt++;
      if (done_o !== 1'b1 || result_o !== 2'b01 || decide_level_o !== 16'd3 || apply_update_o !== 1'b0)
         $display("FAIL sat_done: done=%b res=%b lvl=%0d upd=%b, expected 1 01 3 0",
                  done_o, result_o, decide_level_o, apply_update_o);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 2'b01)
         $display("FAIL after_done: done=%b busy=%b res=%b, expected 0 0 01", done_o, busy_o, result_o);
      else pass_cnt++;
   endtask

   task automatic test_decide;
      bit seen;
      free_vec_i = 8'b0010_1000;
      start_bin(16'd3);
      wait_for(W_DECIDE, 200, seen);
      total_cnt++;
      if (!seen || vars_decided_o !== 8'b0000_1000 || decide_level_o !== 16'd4 ||
          {apply_load_o, apply_update_o, apply_analyze_o, apply_backtrack_o} !== 4'b0)
         $display("FAIL decide_pulse: seen=%b vars=%b lvl=%0d, expected 1 00001000 4", seen,
                  vars_decided_o, decide_level_o);
      else pass_cnt++;
      free_vec_i = 8'h00;
      step(1);
      total_cnt++;
      if (vars_decided_o !== 8'h00 || decide_level_o !== 16'd4)
         $display("FAIL decide_one_cycle: vars=%b lvl=%0d, expected 00000000 4", vars_decided_o, decide_level_o);
      else pass_cnt++;
      wait_for(W_DONE, 200, seen);
      total_cnt++;
      if (!seen || result_o !== 2'b01 || decide_level_o !== 16'd4)
         $display("FAIL decide_done: seen=%b res=%b lvl=%0d, expected 1 01 4", seen, result_o, decide_level_o);
      else pass_cnt++;
      step(1);
   endtask

   task automatic test_conflict_in_bin;
      bit seen;
      int n;
      free_vec_i = 8'b0000_0110;
      max_lvl_i  = 16'd4;
      start_bin(16'd3);
      wait_for(W_DECIDE, 200, seen);
      total_cnt++;
      if (!seen || vars_decided_o !== 8'h02 || decide_level_o !== 16'd4)
         $display("FAIL cib_decide1: seen=%b vars=%h lvl=%0d, expected 1 02 4", seen, vars_decided_o, decide_level_o);
      else pass_cnt++;
      step(1);
      wait_for(W_DECIDE, 50, seen);
      total_cnt++;
      if (!seen || decide_level_o !== 16'd5)
         $display("FAIL cib_decide2: seen=%b lvl=%0d, expected 1 5", seen, decide_level_o);
      else pass_cnt++;
      conflict_i = 1'b1;
      wait_for(W_ANALYZE, 10, seen);
      conflict_i = 1'b0;
      free_vec_i = 8'h00;
      n = 0;
      while (apply_analyze_o === 1'b1 && n < 10) begin
         n++;
         step(1);
      end
      total_cnt++;
      if (!seen || n !== 2)
         $display("FAIL cib_analyze_len: seen=%b cycles=%0d, expected 1 2", seen, n);
      else pass_cnt++;
      total_cnt++;
      if (apply_backtrack_o !== 1'b1 || bkt_lvl_o !== 16'd4 || decide_level_o !== 16'd5)
         $display("FAIL cib_backtrack: bkt_strobe=%b bkt=%0d lvl=%0d, expected 1 4 5",
                  apply_backtrack_o, bkt_lvl_o, decide_level_o);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (apply_backtrack_o !== 1'b0 || decide_level_o !== 16'd4 || busy_o !== 1'b1 || done_o !== 1'b0)
         $display("FAIL cib_after_bkt: bkt_strobe=%b lvl=%0d busy=%b done=%b, expected 0 4 1 0",
                  apply_backtrack_o, decide_level_o, busy_o, done_o);
      else pass_cnt++;
      wait_for(W_DONE, 200, seen);
      total_cnt++;
      if (!seen || result_o !== 2'b01 || decide_level_o !== 16'd4)
         $display("FAIL cib_done: seen=%b res=%b lvl=%0d, expected 1 01 4", seen, result_o, decide_level_o);
      else pass_cnt++;
      step(1);
   endtask

   task automatic test_backtrack_out;
      bit seen;
      bit bkt_seen;
      int n;
      free_vec_i = 8'h01;
      max_lvl_i  = 16'd1;
      start_bin(16'd3);
      wait_for(W_DECIDE, 200, seen);
      conflict_i = 1'b1;
      wait_for(W_ANALYZE, 10, seen);
      conflict_i = 1'b0;
      n = 0;
      bkt_seen = 1'b0;
      while (done_o !== 1'b1 && n < 20) begin
         if (apply_backtrack_o === 1'b1) bkt_seen = 1'b1;
         n++;
         step(1);
      end
      total_cnt++;
      if (!seen || done_o !== 1'b1 || result_o !== 2'b11 || bkt_lvl_o !== 16'd1 || n !== 2)
         $display("FAIL bkt_out_done: done=%b res=%b bkt=%0d cycles=%0d, expected 1 11 1 2",
                  done_o, result_o, bkt_lvl_o, n);
      else pass_cnt++;
      total_cnt++;
      if (bkt_seen !== 1'b0 || apply_backtrack_o !== 1'b0)
         $display("FAIL bkt_out_no_strobe: seen=%b, expected 0", bkt_seen);
      else pass_cnt++;
      step(1);
   endtask

   task automatic test_global_unsat;
      bit seen;
      bit bkt_seen;
      int n;
      free_vec_i = 8'hFF;
      max_lvl_i  = 16'd0;
      start_bin(16'd0);
      wait_for(W_LOAD_END, 40, seen);
      step(1);
      conflict_i = 1'b1;
      step(1);
      total_cnt++;
      if (!seen || apply_analyze_o !== 1'b1 || vars_decided_o !== 8'h00 || apply_update_o !== 1'b0)
         $display("FAIL unsat_priority: ana=%b vars=%h upd=%b, expected 1 00 0",
                  apply_analyze_o, vars_decided_o, apply_update_o);
      else pass_cnt++;
      conflict_i = 1'b0;
      n = 0;
      bkt_seen = 1'b0;
      while (done_o !== 1'b1 && n < 20) begin
         if (apply_backtrack_o === 1'b1) bkt_seen = 1'b1;
         n++;
         step(1);
      end
      total_cnt++;
      if (done_o !== 1'b1 || result_o !== 2'b10 || decide_level_o !== 16'd0 || bkt_seen !== 1'b0)
         $display("FAIL unsat_done: done=%b res=%b lvl=%0d bkt_seen=%b, expected 1 10 0 0",
                  done_o, result_o, decide_level_o, bkt_seen);
      else pass_cnt++;
      step(1);
   endtask

   task automatic test_level_saturation;
      bit seen;
      free_vec_i = 8'h80;
      start_bin(16'hFFFF);
      wait_for(W_DECIDE, 200, seen);
      total_cnt++;
      if (!seen || vars_decided_o !== 8'h80 || decide_level_o !== 16'hFFFF)
         $display("FAIL sat_level: seen=%b vars=%h lvl=%h, expected 1 80 ffff", seen, vars_decided_o, decide_level_o);
      else pass_cnt++;
      free_vec_i = 8'h00;
      wait_for(W_DONE, 200, seen);
      total_cnt++;
      if (!seen || result_o !== 2'b01 || decide_level_o !== 16'hFFFF)
         $display("FAIL sat_level_done: seen=%b res=%b lvl=%h, expected 1 01 ffff", seen, result_o, decide_level_o);
      else pass_cnt++;
      step(1);
   endtask

   task automatic test_reset_mid;
      bit seen;
      bit done_seen;
      free_vec_i = 8'h00;
      start_bin(16'd2);
      wait_for(W_UPDATE, 60, seen);
      step(3);
      rst = 1'b0;
      step(1);
      total_cnt++;
      if (!seen || {apply_load_o, apply_update_o, apply_analyze_o, apply_backtrack_o, busy_o, done_o} !== 6'b0 ||
          result_o !== 2'b00 || decide_level_o !== 16'd0 || clause_idx_o !== 5'd0 || bkt_lvl_o !== 16'd0)
         $display("FAIL mid_reset: upd=%b busy=%b res=%b lvl=%0d idx=%0d bkt=%0d, expected 0 0 00 0 0 0",
                  apply_update_o, busy_o, result_o, decide_level_o, clause_idx_o, bkt_lvl_o);
      else pass_cnt++;
      rst = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done_o === 1'b1) done_seen = 1'b1;
         step(1);
      end
      total_cnt++;
      if (done_seen !== 1'b0 || busy_o !== 1'b0)
         $display("FAIL mid_reset_no_done: done_seen=%b busy=%b, expected 0 0", done_seen, busy_o);
      else pass_cnt++;
   endtask

`ifdef BIN_SEARCH_CTRL_STATS_EN
   task automatic test_stats;
      bit seen;
      free_vec_i = 8'h01;
      max_lvl_i  = 16'd4;
      start_bin(16'd3);
      for (int k = 0; k < 3; k++) begin
         wait_for(W_DECIDE, 200, seen);
         if (k < 2) step(1);
      end
      conflict_i = 1'b1;
      wait_for(W_ANALYZE, 10, seen);
      conflict_i = 1'b0;
      free_vec_i = 8'h00;
      wait_for(W_DONE, 200, seen);
      total_cnt++;
      if (!seen || decision_cnt_o !== 16'd3 || conflict_cnt_o !== 16'd1 || result_o !== 2'b01)
         $display("FAIL stats_counts: seen=%b dec=%0d conf=%0d res=%b, expected 1 3 1 01",
                  seen, decision_cnt_o, conflict_cnt_o, result_o);
      else pass_cnt++;
      step(1);
      start_bin(16'd5);
      total_cnt++;
      if (decision_cnt_o !== 16'd0 || conflict_cnt_o !== 16'd0)
         $display("FAIL stats_clear: dec=%0d conf=%0d, expected 0 0", decision_cnt_o, conflict_cnt_o);
      else pass_cnt++;
      wait_for(W_DONE, 200, seen);
      step(1);
   endtask
`endif

   initial begin
      test_reset();
      test_load_update();
      test_decide();
      test_conflict_in_bin();
      test_backtrack_out();
      test_global_unsat();
      test_level_saturation();
      test_reset_mid();
`ifdef BIN_SEARCH_CTRL_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
